memory_arbiter: RTL and testbench

MEMORY_ARBITER -- requirements
Module: memory_arbiter

---
 rtl/memory_arbiter.sv | 114 +++++++++++
 tb/tb_memory_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// memory_arbiter
//   Two-requester round-robin arbiter in front of a single-port memory.
//   Each access takes three cycles: IDLE (grant and latch), ACCESS (one-cycle
//   read or write strobe, sampled by the memory on the falling edge) and DONE
//   (one-cycle ack to the winner). All outputs come straight from registers.
// Ports
//   i_clock, i_reset (async, active low)
//   i_reqN / i_weN / i_addrN / i_wdataN : requester N access request
//   o_ackN                              : one-cycle completion pulse
//   o_rdata                             : read data, held until the next read
//   o_busy                              : high in ACCESS and DONE
//   o_mem_addr/read/write/data, i_mem_data : memory side
module memory_arbiter #(
  parameter int DATA_SIZE = 14,
  parameter int ADDR_SIZE = 19
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_req0,
  input  logic                 i_req1,
  input  logic                 i_we0,
  input  logic                 i_we1,
  input  logic [ADDR_SIZE-1:0] i_addr0,
  input  logic [ADDR_SIZE-1:0] i_addr1,
  input  logic [DATA_SIZE-1:0] i_wdata0,
  input  logic [DATA_SIZE-1:0] i_wdata1,
  output logic                 o_ack0,
  output logic                 o_ack1,
  output logic [DATA_SIZE-1:0] o_rdata,
  output logic                 o_busy,
  output logic [ADDR_SIZE-1:0] o_mem_addr,
  output logic                 o_mem_read,
  output logic                 o_mem_write,
  output logic [DATA_SIZE-1:0] o_mem_data,
  input  logic [DATA_SIZE-1:0] i_mem_data
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t               r_state;
  logic                 r_last;   // requester granted most recently
  logic                 r_win;    // requester owning the access in flight
  logic                 r_ack0, r_ack1, r_busy, r_mem_read, r_mem_write;
  logic [ADDR_SIZE-1:0] r_mem_addr;
  logic [DATA_SIZE-1:0] r_mem_data, r_rdata;

  // Winner: a lone requester wins; on a tie the one not granted last wins.
  logic                 w_win;
  logic                 w_we;
  logic [ADDR_SIZE-1:0] w_addr;
  logic [DATA_SIZE-1:0] w_wdata;

  assign w_win   = (i_req0 && i_req1) ? ~r_last : i_req1;
  assign w_we    = w_win ? i_we1    : i_we0;
  assign w_addr  = w_win ? i_addr1  : i_addr0;
  assign w_wdata = w_win ? i_wdata1 : i_wdata0;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= S_IDLE;
      r_last      <= 1'b1;       // requester 0 wins the first tie
      r_win       <= 1'b0;
      r_ack0      <= 1'b0;
      r_ack1      <= 1'b0;
      r_busy      <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_data  <= '0;
      r_rdata     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req0 || i_req1) begin
            r_win       <= w_win;
            r_last      <= w_win;
            r_mem_addr  <= w_addr;
            r_mem_data  <= w_wdata;
            r_mem_read  <= ~w_we;
            r_mem_write <= w_we;
            r_busy      <= 1'b1;
            r_state     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          // Memory registered its read data on the falling edge of this cycle.
          if (!r_mem_write) r_rdata <= i_mem_data;
          r_ack0      <= ~r_win;
          r_ack1      <= r_win;
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_ack0      = r_ack0;
  assign o_ack1      = r_ack1;
  assign o_rdata     = r_rdata;
  assign o_busy      = r_busy;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_read  = r_mem_read;
  assign o_mem_write = r_mem_write;
  assign o_mem_data  = r_mem_data;

endmodule

// File: tb/tb_memory_arbiter.sv
// Testbench for memory_arbiter: a transaction-level reference model predicts
// each grant (who, op, addr, data, read result, grant edge) into a queue; a
// monitor on the falling edge compares DUT outputs against the queue head.
module tb_memory_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req [2];
  logic        we  [2];
  logic [18:0] addr[2];
  logic [13:0] wd  [2];
  logic        o_ack0, o_ack1, o_busy, o_mem_read, o_mem_write;
  logic [13:0] o_rdata, o_mem_data, mem_q;
  logic [18:0] o_mem_addr;

  always #5 clk = ~clk;

  memory_arbiter #(.DATA_SIZE(14), .ADDR_SIZE(19)) dut (
    .i_clock(clk), .i_reset(rst_n),
    .i_req0(req[0]), .i_req1(req[1]), .i_we0(we[0]), .i_we1(we[1]),
    .i_addr0(addr[0]), .i_addr1(addr[1]), .i_wdata0(wd[0]), .i_wdata1(wd[1]),
    .o_ack0(o_ack0), .o_ack1(o_ack1), .o_rdata(o_rdata), .o_busy(o_busy),
    .o_mem_addr(o_mem_addr), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
    .o_mem_data(o_mem_data), .i_mem_data(mem_q)
  );

  // Memory: 16 words, aliased on addr[3:0], registered on the falling edge.
  logic [13:0] mem[16] = '{default: 14'h0};
  always @(negedge clk) begin
    if (o_mem_write) mem[o_mem_addr[3:0]] <= o_mem_data;
    if (o_mem_read)  mem_q <= mem[o_mem_addr[3:0]];
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          who;
    logic        we;
    logic [18:0] addr;
    logic [13:0] wdata;
    logic [13:0] rdata;
    int          g;      // rising-edge number of the grant
  } exp_t;

  exp_t        exp_q[$];
  logic [13:0] refmem[16] = '{default: 14'h0};
  int          cyc = 0;
  int          last = 1;
  int          next_free = 0;

  // Transactions are serialized, so a read sees every earlier granted write.
  always @(posedge clk) begin
    exp_t e;
    int   w;
    cyc++;
    if (!rst_n) begin
      last = 1; next_free = 0; exp_q.delete();
    end else if (cyc >= next_free && (req[0] || req[1])) begin
      if (req[0] && req[1]) w = (last == 0) ? 1 : 0;
      else                  w = req[0] ? 0 : 1;
      e.who = w; e.we = we[w]; e.addr = addr[w]; e.wdata = wd[w];
      e.rdata = refmem[addr[w][3:0]]; e.g = cyc;
      if (we[w]) refmem[addr[w][3:0]] = wd[w];
      last = w; next_free = cyc + 3;
      exp_q.push_back(e);
    end
  end

  always @(negedge rst_n) exp_q.delete();

  // ---------------- monitor ----------------
  logic [13:0] exp_rdata = 14'h0;
  int          ack_cnt[2] = '{0, 0};

  always @(negedge clk) begin
    exp_t e;
    bit   s, a;
    if (!rst_n) begin
      exp_rdata = 14'h0;
      chk("rst_ack0", o_ack0, 0);       chk("rst_ack1", o_ack1, 0);
      chk("rst_busy", o_busy, 0);       chk("rst_rd", o_mem_read, 0);
      chk("rst_wr", o_mem_write, 0);    chk("rst_addr", o_mem_addr, 0);
      chk("rst_mdata", o_mem_data, 0);  chk("rst_rdata", o_rdata, 0);
    end else begin
      if (exp_q.size() > 0 && cyc > exp_q[0].g + 1) begin
        checks++; failures++;
        $display("FAIL missing_ack actual=none expected=ack%0d at %0t", exp_q[0].who, $time);
        void'(exp_q.pop_front());
      end
      e = '{who: -1, we: 1'b0, addr: 19'h0, wdata: 14'h0, rdata: 14'h0, g: 0};
      if (exp_q.size() > 0) e = exp_q[0];
      s = (exp_q.size() > 0) && (cyc == e.g);
      a = (exp_q.size() > 0) && (cyc == e.g + 1);
      chk("mem_read",  o_mem_read,  s && !e.we);
      chk("mem_write", o_mem_write, s && e.we);
      chk("busy",      o_busy,      s || a);
      if (s) chk("mem_addr", o_mem_addr, e.addr);
      if (s && e.we) chk("mem_data", o_mem_data, e.wdata);
      chk("ack0", o_ack0, a && e.who == 0);
      chk("ack1", o_ack1, a && e.who == 1);
      if (a) begin
        if (!e.we) exp_rdata = e.rdata;
        void'(exp_q.pop_front());
      end
      chk("rdata", o_rdata, exp_rdata);
      if (o_ack0) ack_cnt[0]++;
      if (o_ack1) ack_cnt[1]++;
    end
  end

  // Protocol properties across all traffic.
  a_excl: assert property (@(posedge clk) disable iff (!rst_n)
            !(o_mem_read && o_mem_write) && !(o_ack0 && o_ack1));
  a_lat:  assert property (@(posedge clk) disable iff (!rst_n)
            (o_mem_read || o_mem_write) |=> (o_ack0 || o_ack1));
  a_done: assert property (@(posedge clk) disable iff (!rst_n)
            (o_ack0 || o_ack1) |=> !(o_ack0 || o_ack1 || o_busy));

  // ---------------- drivers ----------------
  // Present one request and hold it until acked; optionally scramble the
  // request fields while waiting (the model samples them at the grant edge).
  task automatic drive(input int who, input logic w, input logic [18:0] a,
                       input logic [13:0] d, input bit hold, input bit scr);
    int n = 0;
    req[who] = 1'b1; we[who] = w; addr[who] = a; wd[who] = d;
    forever begin
      @(negedge clk);
      if ((who == 0) ? o_ack0 : o_ack1) break;
      if (++n > 30) begin
        checks++; failures++;
        $display("FAIL ack_timeout actual=no_ack expected=ack%0d at %0t", who, $time);
        break;
      end
      if (scr && $urandom_range(0, 1) == 1) begin
        we[who] = 1'($urandom); addr[who] = 19'($urandom); wd[who] = 14'($urandom);
      end
    end
    @(posedge clk); #1;
    if (!hold) req[who] = 1'b0;
  endtask

  task automatic rnd_driver(input int who, input int n);
    bit hold = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (!hold) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
      hold = (i < n - 1) && ($urandom_range(0, 1) == 1);
      drive(who, 1'($urandom), 19'($urandom), 14'($urandom), hold, 1'b1);
    end
  endtask

  task automatic wait_strobe(output bit ok);
    int n = 0;
    ok = 1'b1;
    do begin
      @(negedge clk);
      if (++n > 20) begin
        ok = 1'b0; checks++; failures++;
        $display("FAIL strobe_timeout actual=none expected=strobe at %0t", $time);
      end
    end while (ok && !(o_mem_read || o_mem_write));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          base1;
    bit          ok;
    logic [13:0] vals[4];
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = 19'h0; wd[i] = 14'h0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Two ties: requester 0 first after reset, then alternation restarts at 0.
    fork
      drive(0, 1'b0, 19'd3, 14'h0, 1'b0, 1'b0);
      drive(1, 1'b0, 19'd4, 14'h0, 1'b0, 1'b0);
    join
    fork
      drive(0, 1'b0, 19'd3, 14'h0, 1'b0, 1'b0);
      drive(1, 1'b0, 19'd4, 14'h0, 1'b0, 1'b0);
    join

    // Write then read from requester 0.
    drive(0, 1'b1, 19'h00005, 14'h1ABC, 1'b0, 1'b0);
    drive(0, 1'b0, 19'h00005, 14'h0, 1'b0, 1'b0);
    chk("wr_rd_rdata", o_rdata, 14'h1ABC);

    // Address change after grant must not disturb the access.
    fork
      drive(0, 1'b0, 19'd7, 14'h0, 1'b0, 1'b0);
      begin
        wait_strobe(ok);
        addr[0] = 19'd9;
        #1 chk("addr_hold", o_mem_addr, 19'd7);
      end
    join

    // Back-to-back writes from requester 1 with req held high throughout.
    base1 = ack_cnt[1];
    for (int i = 0; i < 4; i++) begin
      vals[i] = 14'($urandom);
      drive(1, 1'b1, 19'(i), vals[i], i < 3, 1'b0);
    end
    chk("b2b_acks", ack_cnt[1] - base1, 4);
    for (int i = 0; i < 4; i++) chk("b2b_mem", mem[i], vals[i]);

    // Random concurrent traffic on both ports.
    fork
      rnd_driver(0, 40);
      rnd_driver(1, 40);
    join

    // Asynchronous reset in the middle of a read access.
    @(posedge clk); #1;
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 19'h11;
    wait_strobe(ok);
    #2 rst_n = 1'b0; req[0] = 1'b0;
    #1;
    chk("async_rd",   o_mem_read, 0);  chk("async_wr",   o_mem_write, 0);
    chk("async_ack0", o_ack0, 0);      chk("async_ack1", o_ack1, 0);
    chk("async_busy", o_busy, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (4) @(posedge clk); #1;

    // Traffic after reset: tie goes to requester 0 again.
    fork
      drive(0, 1'b0, 19'h00005, 14'h0, 1'b0, 1'b0);
      drive(1, 1'b0, 19'd2, 14'h0, 1'b0, 1'b0);
    join
    fork
      rnd_driver(0, 20);
      rnd_driver(1, 20);
    join
    repeat (5) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
